ascon_seq_ctrl: RTL and testbench

ASCON_SEQ_CTRL -- requirements
Module: ascon_seq_ctrl

---
 rtl/ascon_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_ascon_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_seq_ctrl.sv
// rtl/ascon_seq_ctrl.sv - Ascon permutation sequencer: command decode, round stepping, optional state readout.
// Optional feature: define ASCON_READOUT_EN to enable mode 5 (320-cycle state readout).
module ascon_seq_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_mode,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       state_load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [2:0] operation_mode,
  output logic       operation_ready,
  output logic       done,
  output logic       err,
  output logic       state_shift_en,
  output logic [2:0] state_shift_sel
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
`ifdef ASCON_READOUT_EN
    , READOUT
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic [3:0] idx_q;
  logic [2:0] mode_q;
  logic       err_q;
  logic [3:0] rounds_n;
  logic       last_round;
  logic       accept;
  logic       is_long, is_short, is_rd, legal;

  assign accept   = cmd_valid && cmd_ready;
  assign is_long  = (cmd_mode == 3'd1) || (cmd_mode == 3'd4);
  assign is_short = (cmd_mode == 3'd2) || (cmd_mode == 3'd3);
`ifdef ASCON_READOUT_EN
  assign is_rd    = (cmd_mode == 3'd5);
`else
  assign is_rd    = 1'b0;
`endif
  assign legal    = is_long || is_short || is_rd;

  // Round count follows the latched mode, which is stable from LOAD onwards.
  assign rounds_n   = ((mode_q == 3'd1) || (mode_q == 3'd4)) ? 4'(ROUNDS_A) : 4'(ROUNDS_B);
  assign last_round = (cnt_q == rounds_n - 4'd1);

  assign cmd_ready       = (state_q == IDLE) && !abort;
  assign operation_ready = (state_q == IDLE) || (state_q == DONE);
  assign operation_mode  = mode_q;
  assign round_idx       = idx_q;
  assign err             = err_q;

`ifdef ASCON_READOUT_EN
  logic [8:0] rd_cnt_q;
  logic       shift_en;
  assign state_shift_en  = shift_en;
  assign state_shift_sel = rd_cnt_q[8:6];
`else
  assign state_shift_en  = 1'b0;
  assign state_shift_sel = 3'd0;
`endif

  always_comb begin
    state_d    = state_q;
    state_load = 1'b0;
    round_en   = 1'b0;
    done       = 1'b0;
`ifdef ASCON_READOUT_EN
    shift_en   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept && legal) begin
`ifdef ASCON_READOUT_EN
          state_d = is_rd ? READOUT : LOAD;
`else
          state_d = LOAD;
`endif
        end
      end
      LOAD: begin
        state_load = 1'b1;
        state_d    = abort ? IDLE : ROUND;
      end
      ROUND: begin
        round_en = 1'b1;
        if (abort)           state_d = IDLE;
        else if (last_round) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
`ifdef ASCON_READOUT_EN
      READOUT: begin
        shift_en = 1'b1;
        if (abort)                   state_d = IDLE;
        else if (rd_cnt_q == 9'd319) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      mode_q  <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !legal;
      if (accept && legal) mode_q <= cmd_mode;
      if (state_q == LOAD && !abort) begin
        cnt_q <= 4'd0;
        idx_q <= 4'd12 - rounds_n;
      end
      // Counters stop on the last round so round_idx keeps reading 11 afterwards.
      if (state_q == ROUND && !abort && !last_round) begin
        cnt_q <= cnt_q + 4'd1;
        idx_q <= idx_q + 4'd1;
      end
    end
  end

`ifdef ASCON_READOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 9'd0;
    end else if (state_q == IDLE && accept && is_rd) begin
      rd_cnt_q <= 9'd0;
    end else if (state_q == READOUT && !abort && rd_cnt_q != 9'd319) begin
      rd_cnt_q <= rd_cnt_q + 9'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ascon_seq_ctrl.sv
// tb/tb_ascon_seq_ctrl.sv - Scoreboard bench for ascon_seq_ctrl: expected strobe events queued by stimulus, checked by a monitor.
module tb_ascon_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_mode = 3'd0;
  logic       abort = 1'b0;
  logic       cmd_ready, state_load, round_en, operation_ready, done, err, state_shift_en;
  logic [3:0] round_idx;
  logic [2:0] operation_mode, state_shift_sel;

  ascon_seq_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
    .cmd_ready(cmd_ready), .abort(abort), .state_load(state_load), .round_en(round_en),
    .round_idx(round_idx), .operation_mode(operation_mode), .operation_ready(operation_ready),
    .done(done), .err(err), .state_shift_en(state_shift_en), .state_shift_sel(state_shift_sel)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 state_load, 2 round_en (val=round_idx), 3 done, 4 err, 5 state_shift_en (val=sel)
  typedef struct { int kind; int cyc; int val; } ev_t;
  ev_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int val);
    ev_t e;
    e.kind = kind; e.cyc = c; e.val = val;
    q.push_back(e);
  endtask

  task automatic push_round_op(input int t, input int m);
    int n;
    n = (m == 1 || m == 4) ? 12 : 6;
    push(1, t + 1, 0);
    for (int i = 0; i < n; i++) push(2, t + 2 + i, 12 - n + i);
    push(3, t + 2 + n, 0);
  endtask

  always @(negedge clk) begin
    int n, k, v;
    ev_t e;
    n = $countones({state_load, round_en, done, err, state_shift_en});
    if (n > 1) check("strobes_exclusive", n, 1);
    if (n >= 1) begin
      k = state_load ? 1 : round_en ? 2 : done ? 3 : err ? 4 : 5;
      v = (k == 2) ? int'(round_idx) : (k == 5) ? int'(state_shift_sel) : 0;
      if (q.size() == 0) begin
        check("unexpected_strobe_kind", k, 0);
      end else begin
        e = q.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        check("event_value", v, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    int b;
    b = 0;
    while (cyc < c && b < 2000) begin step(); b++; end
  endtask

  task automatic issue(input logic [2:0] m, output int t);
    step();
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    t = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (q.size() > 0 && b < 1000) begin step(); b++; end
    if (q.size() > 0) begin
      check("drain_timeout_pending", q.size(), 0);
      q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_operation_ready", operation_ready, 1);
    check("rst_operation_mode", operation_mode, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_shift_sel", state_shift_sel, 0);
    check("rst_strobes", {state_load, round_en, done, err, state_shift_en}, 0);
    rst_n = 1'b1;

    // mode 1: 12 rounds, idx 0..11
    issue(3'd1, t);
    push_round_op(t, 1);
    check("m1_op_ready_t1", operation_ready, 0);
    check("m1_op_mode", operation_mode, 1);
    wait_to(t + 13);
    check("m1_op_ready_t13", operation_ready, 0);
    wait_to(t + 14);
    check("m1_op_ready_done", operation_ready, 1);
    drain();

    // mode 3: 6 rounds, idx 6..11, round_idx holds afterwards
    issue(3'd3, t);
    push_round_op(t, 3);
    check("m3_op_mode", operation_mode, 3);
    drain();
    check("m3_idx_hold", round_idx, 11);

    // mode 7 illegal, then mode 2 accepted immediately at T+1
    step();
    cmd_valid = 1'b1;
    cmd_mode  = 3'd7;
    t = cyc;
    push(4, t + 1, 0);
    step();
    check("m7_op_ready", operation_ready, 1);
    check("m7_op_mode_kept", operation_mode, 3);
    check("m7_cmd_ready_t1", cmd_ready, 1);
    cmd_mode = 3'd2;
    push_round_op(t + 1, 2);
    step();
    cmd_valid = 1'b0;
    drain();

    // abort on the 4th round of mode 4
    issue(3'd4, t);
    push(1, t + 1, 0);
    for (int i = 0; i < 4; i++) push(2, t + 2 + i, i);
    wait_to(t + 5);
    abort = 1'b1;
    step();
    check("abort_op_ready", operation_ready, 1);
    check("abort_strobes", {state_load, round_en, done, err, state_shift_en}, 0);
    check("abort_cmd_ready_blocked", cmd_ready, 0);
    abort = 1'b0;
    #1;
    check("abort_cmd_ready_after", cmd_ready, 1);
    drain();

    // abort in IDLE blocks acceptance
    step();
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 3'd1;
    #1;
    check("idle_abort_cmd_ready", cmd_ready, 0);
    step();
    step();
    cmd_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort_op_ready", operation_ready, 1);
    repeat (4) step();

    // abort during DONE does not suppress the done pulse
    issue(3'd3, t);
    push_round_op(t, 3);
    wait_to(t + 8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    drain();

    // reset during ROUND of mode 2, then a fresh mode 2 on the first edge after release
    issue(3'd2, t);
    push(1, t + 1, 0);
    push(2, t + 2, 6);
    push(2, t + 3, 7);
    wait_to(t + 4);
    rst_n = 1'b0;
    #1;
    check("midrst_round_en", round_en, 0);
    check("midrst_op_ready", operation_ready, 1);
    check("midrst_op_mode", operation_mode, 0);
    check("midrst_round_idx", round_idx, 0);
    step();
    step();
    rst_n = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 3'd2;
    t = cyc;
    push_round_op(t, 2);
    step();
    cmd_valid = 1'b0;
    drain();

    // mode 5: readout when enabled, illegal otherwise
    issue(3'd5, t);
`ifdef ASCON_READOUT_EN
    for (int k = 0; k < 320; k++) push(5, t + 1 + k, k / 64);
    push(3, t + 321, 0);
    check("m5_op_mode", operation_mode, 5);
`else
    push(4, t + 1, 0);
    check("m5_op_mode_kept", operation_mode, 2);
    check("m5_op_ready", operation_ready, 1);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
